// File: rtl/wall_field.sv
// Scrolling wall field: WALL_NUM walls move left on each frame tick, respawn at the back with an
// LFSR gap height, and count passed walls. Optional collision logic is enabled by WALL_COLLIDE_EN.
module wall_field #(
  parameter int unsigned WALL_NUM     = 4,
  parameter int unsigned X_W          = 11,
  parameter int unsigned Y_W          = 11,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned WALL_SPACING = 160,
  parameter int unsigned GAP_MIN      = 40,
  parameter int unsigned START        = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned WALL_W       = 32,
  parameter int unsigned GAP_H        = 120,
  // Reset value of pass_count; nonzero only for bring-up of the saturation path.
  parameter logic [15:0] PASS_INIT    = 16'h0000
) (
  input  logic                    pixel_clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    run,
  input  logic                    restart,
  input  logic [3:0]              speed,
  input  logic [X_W-1:0]          bird_x,
  input  logic [Y_W-1:0]          bird_y,
  output logic [WALL_NUM*X_W-1:0] wall_x,
  output logic [WALL_NUM*Y_W-1:0] wall_y,
  output logic [WALL_NUM-1:0]     wall_valid,
  output logic                    respawn,
  output logic [15:0]             pass_count,
  output logic                    hit
);

  localparam int unsigned Span = WALL_NUM * WALL_SPACING;
  localparam int unsigned XE   = X_W + 1;
  localparam int unsigned YE   = Y_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StHalt} state_e;

  state_e               state_q;
  logic [X_W-1:0]       x_q [WALL_NUM];
  logic [X_W-1:0]       x_d [WALL_NUM];
  logic [Y_W-1:0]       y_q [WALL_NUM];
  logic [Y_W-1:0]       y_d [WALL_NUM];
  logic [15:0]          lfsr_q, lfsr_d;
  logic [15:0]          pass_q, pass_d;
  logic [16:0]          pass_sum;
  logic                 respawn_q;
  logic                 hit_q, hit_d;
  logic                 chk_q;
  logic                 tick_go;
  logic [WALL_NUM-1:0]  wrap;
  logic [X_W-1:0]       spd_x;
  logic                 coll, in_x, in_gap;

  function automatic logic [X_W-1:0] init_x(input int unsigned k);
    return X_W'(SCREEN_W + k * WALL_SPACING);
  endfunction

  function automatic logic [Y_W-1:0] init_y(input int unsigned k);
    return Y_W'(GAP_MIN + ((START + 37 * k) % 256));
  endfunction

  // Low byte of v rotated left by n.
  function automatic logic [7:0] rotl_low(input logic [15:0] v, input int unsigned n);
    logic [7:0] r;
    for (int unsigned b = 0; b < 8; b++) begin
      r[b] = v[4'((b + 16 - (n % 16)) % 16)];
    end
    return r;
  endfunction

  assign spd_x  = X_W'(speed);
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    tick_go = frame_tick && (state_q == StRun) && !hit_q;
    wrap    = '0;
    for (int unsigned k = 0; k < WALL_NUM; k++) begin
      x_d[k] = x_q[k];
      y_d[k] = y_q[k];
      if (tick_go) begin
        if (x_q[k] >= spd_x) begin
          x_d[k] = x_q[k] - spd_x;
        end else begin
          x_d[k]  = x_q[k] + X_W'(Span) - spd_x;
          y_d[k]  = Y_W'(GAP_MIN) + Y_W'(rotl_low(lfsr_q, 2 * k));
          wrap[k] = 1'b1;
        end
      end
    end
    // 17-bit sum so the carry flags saturation
    pass_sum = {1'b0, pass_q};
    for (int unsigned k = 0; k < WALL_NUM; k++) begin
      pass_sum = pass_sum + 17'(wrap[k]);
    end
    pass_d = pass_sum[16] ? 16'hFFFF : pass_sum[15:0];
  end

  always_comb begin
    coll   = 1'b0;
    in_x   = 1'b0;
    in_gap = 1'b0;
    for (int unsigned k = 0; k < WALL_NUM; k++) begin
      in_x   = (XE'(bird_x) >= XE'(x_q[k])) && (XE'(bird_x) < XE'(x_q[k]) + XE'(WALL_W));
      in_gap = (YE'(bird_y) >= YE'(y_q[k])) && (YE'(bird_y) < YE'(y_q[k]) + YE'(GAP_H));
      if (in_x && !in_gap) coll = 1'b1;
    end
  end

`ifdef WALL_COLLIDE_EN
  assign hit_d = hit_q | (chk_q & coll);
`else
  logic unused_collide;
  assign unused_collide = coll ^ chk_q;
  assign hit_d          = 1'b0;
`endif

  always_ff @(posedge pixel_clk) begin
    if (!reset || restart) begin
      state_q   <= StIdle;
      for (int unsigned k = 0; k < WALL_NUM; k++) begin
        x_q[k] <= init_x(k);
        y_q[k] <= init_y(k);
      end
      lfsr_q    <= LFSR_SEED;
      pass_q    <= PASS_INIT;
      respawn_q <= 1'b0;
      hit_q     <= 1'b0;
      chk_q     <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < WALL_NUM; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
      lfsr_q    <= lfsr_d;
      pass_q    <= pass_d;
      respawn_q <= |wrap;
      chk_q     <= tick_go;
      hit_q     <= hit_d;
      case (state_q)
        StIdle:  if (run) state_q <= StRun;
        StRun: begin
          if (hit_q)     state_q <= StHalt;
          else if (!run) state_q <= StPause;
        end
        StPause: if (run) state_q <= StRun;
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < WALL_NUM; k++) begin
      wall_x[k*X_W +: X_W] = x_q[k];
      wall_y[k*Y_W +: Y_W] = y_q[k];
    end
  end

  assign wall_valid = (state_q == StIdle) ? '0 : '1;
  assign respawn    = respawn_q;
  assign pass_count = pass_q;
  assign hit        = hit_q;

endmodule
